im_fetch_arbiter: RTL
=====================

IM_FETCH_ARBITER -- requirements
Module: im_fetch_arbiter

Interface
REQ-001 Parameter BASE_ADDR, default 32'h00003000, byte address of instruction-memory word 0.
REQ-002 Parameter AW, default 11, memory word-address width (2048 words).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 f_req  in  1  fetch-port request; held until f_gnt.
REQ-006 f_addr  in  32  fetch byte address (PC).
REQ-007 f_gnt  out  1  fetch request accepted this cycle (combinational).
REQ-008 f_rvalid  out  1  fetch response valid.
REQ-009 f_rdata  out  32  fetched instruction.
REQ-010 f_fault  out  1  fetch address out of range or misaligned, qualified by f_rvalid.
REQ-011 l_req  in  1  loader-port request; held until l_gnt.
REQ-012 l_we  in  1  loader write (1) / read (0).
REQ-013 l_lock  in  1  loader requests exclusive ownership of memory.
REQ-014 l_addr  in  32  loader byte address.
REQ-015 l_wdata  in  32  loader write data.
REQ-016 l_gnt  out  1  loader request accepted this cycle (combinational).
REQ-017 l_rvalid  out  1  loader response (read data or write ack) valid.
REQ-018 l_rdata  out  32  loader read data; 0 for write acks.
REQ-019 l_fault  out  1  loader address fault, qualified by l_rvalid.
REQ-020 mem_en, mem_we  out  1 each  memory strobe and write enable.
REQ-021 mem_addr  out  AW  memory word address; mem_wdata out 32; mem_rdata in 32, valid one cycle after mem_en without mem_we.

Function
REQ-022 Translation: word index = (addr - BASE_ADDR) >> 2, AW bits; valid iff addr[1:0]==0 and BASE_ADDR <= addr < BASE_ADDR + 4*2^AW (compare in 33 bits, no wrap).
REQ-023 At most one grant per cycle; grant asserted same cycle as request when selected.
REQ-024 Single requester (state FREE): granted immediately.
REQ-025 Both requesting (state FREE): round-robin; rr_ptr selects the port not granted last; after reset rr_ptr favours fetch.
REQ-026 rr_ptr updates only on a grant, to point at the other port.
REQ-027 States FREE, LOCKED; FREE->LOCKED when l_gnt with l_lock=1; LOCKED->FREE on first cycle l_lock=0 with no loader grant that cycle.
REQ-028 In LOCKED: f_gnt=0; loader granted whenever l_req=1.
REQ-029 Granted valid access: mem_en=1 same cycle, mem_we=l_we for loader, 0 for fetch.
REQ-030 Granted invalid access: mem_en=0, no write occurs; response still returned with fault=1, rdata=0.
REQ-031 Response exactly one cycle after grant: rvalid pulses one cycle on the granted port; rdata=mem_rdata for valid reads.
REQ-032 Back-to-back grants every cycle permitted; responses stay in grant order, one per cycle.
REQ-033 Loader write at cycle N then fetch read of same word at N+1 returns the new data.
REQ-034 Outputs with rvalid=0 hold rdata=0, fault=0.

Reset
REQ-035 rst_n low: immediately state=FREE, rr_ptr=fetch, f_rvalid=l_rvalid=0, rdata=0, fault=0, mem_en=mem_we=0 regardless of requests.
REQ-036 Reset during an outstanding access discards its response; first grant allowed on first edge after rst_n rises.

Verification
REQ-037 Fetch only, f_addr=32'h00003004 -> f_gnt same cycle, mem_addr=1, f_rvalid next cycle with mem_rdata, f_fault=0.
REQ-038 f_addr=32'h00005000 and 32'h00003002 -> f_gnt=1, mem_en=0, next cycle f_rvalid=1, f_fault=1, f_rdata=0.
REQ-039 f_req and l_req held 4 cycles from reset -> grants F,L,F,L.
REQ-040 l_lock=1 write 32'hDEADBEEF to 32'h00004180 with f_req held -> f_gnt=0 until l_lock drops; then fetch of 32'h00004180 returns 32'hDEADBEEF, mem_addr=11'h460.
REQ-041 rst_n asserted cycle after a fetch grant -> no f_rvalid; all outputs 0 while low.

Source files
------------

// File: rtl/im_fetch_arbiter.sv
`timescale 1ns/1ps
// Two-port arbiter for one single-ported instruction memory: CPU fetch port
// and loader port, with round-robin sharing, loader lock and range checks.
module im_fetch_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'h00003000,
    parameter int unsigned AW        = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    // fetch port
    input  logic          f_req,
    input  logic [31:0]   f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [31:0]   f_rdata,
    output logic          f_fault,
    // loader port
    input  logic          l_req,
    input  logic          l_we,
    input  logic          l_lock,
    input  logic [31:0]   l_addr,
    input  logic [31:0]   l_wdata,
    output logic          l_gnt,
    output logic          l_rvalid,
    output logic [31:0]   l_rdata,
    output logic          l_fault,
    // memory port
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam int unsigned SPAN_SHIFT = AW + 2;
    localparam logic [32:0] LO_BOUND   = {1'b0, BASE_ADDR};
    localparam logic [32:0] HI_BOUND   = LO_BOUND + (33'(1) << SPAN_SHIFT);

    typedef enum logic {
        ST_FREE,
        ST_LOCKED
    } state_e;

    typedef enum logic {
        PORT_F,
        PORT_L
    } port_e;

    // Bounds are compared in 33 bits so the top of the window cannot wrap.
    function automatic logic addr_ok(input logic [31:0] a);
        logic [32:0] ax;
        ax = {1'b0, a};
        return (a[1:0] == 2'b00) && (ax >= LO_BOUND) && (ax < HI_BOUND);
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
        return AW'((a - BASE_ADDR) >> 2);
    endfunction

    state_e      state_q, state_d;
    port_e       rr_q, rr_d;

    logic        gnt_f, gnt_l;
    logic [31:0] sel_addr;
    logic        sel_ok;

    logic        f_rvalid_q, f_rvalid_d;
    logic        f_fault_q, f_fault_d;
    logic        f_rd_q, f_rd_d;
    logic        l_rvalid_q, l_rvalid_d;
    logic        l_fault_q, l_fault_d;
    logic        l_rd_q, l_rd_d;

    // Grant selection, lock FSM, memory strobe and next response state.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        gnt_f      = 1'b0;
        gnt_l      = 1'b0;
        f_rvalid_d = 1'b0;
        f_fault_d  = 1'b0;
        f_rd_d     = 1'b0;
        l_rvalid_d = 1'b0;
        l_fault_d  = 1'b0;
        l_rd_d     = 1'b0;

        case (state_q)
            ST_FREE: begin
                if (f_req && l_req) begin
                    gnt_f = (rr_q == PORT_F);
                    gnt_l = (rr_q == PORT_L);
                end else begin
                    gnt_f = f_req;
                    gnt_l = l_req;
                end
            end
            ST_LOCKED: begin
                gnt_l = l_req;
            end
            default: begin
                gnt_f = 1'b0;
                gnt_l = 1'b0;
            end
        endcase

        // Nothing may be granted or strobed while reset is held.
        if (!rst_n) begin
            gnt_f = 1'b0;
            gnt_l = 1'b0;
        end

        case (state_q)
            ST_FREE:   if (gnt_l && l_lock)   state_d = ST_LOCKED;
            ST_LOCKED: if (!l_lock && !gnt_l) state_d = ST_FREE;
            default:   state_d = ST_FREE;
        endcase

        if (gnt_f) begin
            rr_d = PORT_L;
        end else if (gnt_l) begin
            rr_d = PORT_F;
        end

        sel_addr = gnt_l ? l_addr : f_addr;
        sel_ok   = addr_ok(sel_addr);

        f_rvalid_d = gnt_f;
        f_fault_d  = gnt_f && !sel_ok;
        f_rd_d     = gnt_f && sel_ok;
        l_rvalid_d = gnt_l;
        l_fault_d  = gnt_l && !sel_ok;
        l_rd_d     = gnt_l && sel_ok && !l_we;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FREE;
            rr_q       <= PORT_F;
            f_rvalid_q <= 1'b0;
            f_fault_q  <= 1'b0;
            f_rd_q     <= 1'b0;
            l_rvalid_q <= 1'b0;
            l_fault_q  <= 1'b0;
            l_rd_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            f_rvalid_q <= f_rvalid_d;
            f_fault_q  <= f_fault_d;
            f_rd_q     <= f_rd_d;
            l_rvalid_q <= l_rvalid_d;
            l_fault_q  <= l_fault_d;
            l_rd_q     <= l_rd_d;
        end
    end

    assign f_gnt     = gnt_f;
    assign l_gnt     = gnt_l;

    assign mem_en    = (gnt_f || gnt_l) && sel_ok;
    assign mem_we    = mem_en && gnt_l && l_we;
    assign mem_addr  = word_idx(sel_addr);
    assign mem_wdata = l_wdata;

    // Read data arrives from the memory in the response cycle.
    assign f_rvalid  = f_rvalid_q;
    assign f_fault   = f_fault_q;
    assign f_rdata   = f_rd_q ? mem_rdata : 32'h0;
    assign l_rvalid  = l_rvalid_q;
    assign l_fault   = l_fault_q;
    assign l_rdata   = l_rd_q ? mem_rdata : 32'h0;

endmodule
